// File: rtl/mesh_feed_scheduler_if.sv
// Job, upstream stream and mesh-edge signals of the feed scheduler.
// The scheduler side uses the master modport and the environment uses the slave modport.
interface mesh_feed_scheduler_if #(
    parameter int DATA_W    = 32,
    parameter int CFG_W     = 64,
    parameter int MAX_BEATS = 16
);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    logic                job_valid;
    logic                job_ready;
    logic [CFG_W-1:0]    job_cfg;
    logic [CNT_W-1:0]    job_beats;
    logic                job_systolic;
    logic                abort;
    logic                src_valid;
    logic                src_ready;
    logic [2*DATA_W-1:0] src_data;
    logic                ii_load;
    logic                ii_dir;
    logic [DATA_W-1:0]   ii_data_1;
    logic [DATA_W-1:0]   ii_data_2;
    logic [CFG_W-1:0]    ii_cfg;
    logic                ii_systolic;
    logic                busy;
    logic                job_done;
    logic                job_err;
    logic                job_aborted;

    modport master (
        input  job_valid, job_cfg, job_beats, job_systolic, abort, src_valid, src_data,
        output job_ready, src_ready, ii_load, ii_dir, ii_data_1, ii_data_2, ii_cfg,
               ii_systolic, busy, job_done, job_err, job_aborted
    );

    modport slave (
        output job_valid, job_cfg, job_beats, job_systolic, abort, src_valid, src_data,
        input  job_ready, src_ready, ii_load, ii_dir, ii_data_1, ii_data_2, ii_cfg,
               ii_systolic, busy, job_done, job_err, job_aborted
    );
endinterface

// File: rtl/mesh_feed_scheduler.sv
// Per-job sequencer for one mesh edge interface: config, west beats, north beats,
// then a drain that is stretched for systolic jobs so the wavefront clears the array.
module mesh_feed_scheduler #(
    parameter int DATA_W    = 32,
    parameter int CFG_W     = 64,
    parameter int MESH_ROWS = 4,
    parameter int MESH_COLS = 4,
    parameter int MAX_BEATS = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    mesh_feed_scheduler_if.master  bus
);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    localparam int DRN_W = $clog2(MESH_ROWS + MESH_COLS);
    localparam logic [CNT_W-1:0] MAX_B        = CNT_W'(MAX_BEATS);
    localparam logic [DRN_W-1:0] SYS_DRN_LAST = DRN_W'(MESH_ROWS + MESH_COLS - 2);

    typedef enum logic [2:0] {IDLE, CFG, FEED_W, FEED_N, DRAIN, DONE} state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  beats_reg;
    logic [CNT_W-1:0]  beat_cnt_reg;
    logic [DRN_W-1:0]  drain_cnt_reg;
    logic              job_ready_reg;
    logic              src_ready_reg;
    logic              ii_load_reg;
    logic              ii_dir_reg;
    logic [DATA_W-1:0] ii_data_1_reg;
    logic [DATA_W-1:0] ii_data_2_reg;
    logic [CFG_W-1:0]  ii_cfg_reg;
    logic              ii_systolic_reg;
    logic              busy_reg;
    logic              job_done_reg;
    logic              job_err_reg;
    logic              job_aborted_reg;

    logic              accept;
    logic              beats_bad;
    logic [DRN_W-1:0]  drain_last;

    // abort wins over a pair offered in the same cycle
    assign accept     = bus.src_valid & src_ready_reg & ~bus.abort;
    assign beats_bad  = (bus.job_beats == '0) || (bus.job_beats > MAX_B);
    assign drain_last = ii_systolic_reg ? SYS_DRN_LAST : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            beats_reg       <= '0;
            beat_cnt_reg    <= '0;
            drain_cnt_reg   <= '0;
            job_ready_reg   <= 1'b0;
            src_ready_reg   <= 1'b0;
            ii_load_reg     <= 1'b1;
            ii_dir_reg      <= 1'b1;
            ii_data_1_reg   <= '0;
            ii_data_2_reg   <= '0;
            ii_cfg_reg      <= '0;
            ii_systolic_reg <= 1'b0;
            busy_reg        <= 1'b0;
            job_done_reg    <= 1'b0;
            job_err_reg     <= 1'b0;
            job_aborted_reg <= 1'b0;
        end else begin
            ii_load_reg     <= 1'b1;
            job_done_reg    <= 1'b0;
            job_err_reg     <= 1'b0;
            job_aborted_reg <= 1'b0;
            if (state_reg != IDLE && bus.abort) begin
                state_reg       <= IDLE;
                beat_cnt_reg    <= '0;
                drain_cnt_reg   <= '0;
                src_ready_reg   <= 1'b0;
                busy_reg        <= 1'b0;
                job_ready_reg   <= 1'b1;
                job_aborted_reg <= 1'b1;
            end else begin
                case (state_reg)
                    IDLE: begin
                        job_ready_reg <= 1'b1;
                        if (bus.job_valid && job_ready_reg) begin
                            if (beats_bad) begin
                                job_err_reg <= 1'b1;
                            end else begin
                                // config word is presented while the FSM sits in CFG
                                beats_reg       <= bus.job_beats;
                                ii_cfg_reg      <= bus.job_cfg;
                                ii_systolic_reg <= bus.job_systolic;
                                ii_load_reg     <= 1'b0;
                                ii_dir_reg      <= 1'b1;
                                ii_data_1_reg   <= '0;
                                ii_data_2_reg   <= '0;
                                busy_reg        <= 1'b1;
                                job_ready_reg   <= 1'b0;
                                state_reg       <= CFG;
                            end
                        end
                    end
                    CFG: begin
                        src_ready_reg <= 1'b1;
                        state_reg     <= FEED_W;
                    end
                    FEED_W, FEED_N: begin
                        if (accept) begin
                            ii_load_reg   <= 1'b0;
                            ii_dir_reg    <= (state_reg == FEED_W);
                            ii_data_1_reg <= bus.src_data[DATA_W-1:0];
                            ii_data_2_reg <= bus.src_data[2*DATA_W-1:DATA_W];
                            if (beat_cnt_reg == beats_reg - 1'b1) begin
                                beat_cnt_reg <= '0;
                                if (state_reg == FEED_W) begin
                                    state_reg <= FEED_N;
                                end else begin
                                    src_ready_reg <= 1'b0;
                                    drain_cnt_reg <= '0;
                                    state_reg     <= DRAIN;
                                end
                            end else begin
                                beat_cnt_reg <= beat_cnt_reg + 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (drain_cnt_reg == drain_last) begin
                            drain_cnt_reg <= '0;
                            job_done_reg  <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            drain_cnt_reg <= drain_cnt_reg + 1'b1;
                        end
                    end
                    DONE: begin
                        busy_reg      <= 1'b0;
                        job_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign bus.job_ready   = job_ready_reg;
    assign bus.src_ready   = src_ready_reg;
    assign bus.ii_load     = ii_load_reg;
    assign bus.ii_dir      = ii_dir_reg;
    assign bus.ii_data_1   = ii_data_1_reg;
    assign bus.ii_data_2   = ii_data_2_reg;
    assign bus.ii_cfg      = ii_cfg_reg;
    assign bus.ii_systolic = ii_systolic_reg;
    assign bus.busy        = busy_reg;
    assign bus.job_done    = job_done_reg;
    assign bus.job_err     = job_err_reg;
    assign bus.job_aborted = job_aborted_reg;
endmodule

// File: tb/tb_mesh_feed_scheduler.sv
// Directed bench for mesh_feed_scheduler: reset, plain and systolic jobs, source gaps,
// illegal beat counts and abort, with hand-derived cycle timing.
module tb_mesh_feed_scheduler;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mesh_feed_scheduler_if #(.DATA_W(32), .CFG_W(64), .MAX_BEATS(16)) bus ();

    mesh_feed_scheduler #(
        .DATA_W(32), .CFG_W(64), .MESH_ROWS(4), .MESH_COLS(4), .MAX_BEATS(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pair(input int k);
        logic [31:0] w1;
        logic [31:0] w2;
        w1 = 32'hA000_0000 | 32'(k);
        w2 = 32'hB000_0000 | 32'(k);
        return {w2, w1};
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_load"}, 64'(bus.ii_load), 64'd1);
        chk({tag, "_dir"}, 64'(bus.ii_dir), 64'd1);
        chk({tag, "_data1"}, 64'(bus.ii_data_1), 64'd0);
        chk({tag, "_data2"}, 64'(bus.ii_data_2), 64'd0);
        chk({tag, "_cfg"}, bus.ii_cfg, 64'd0);
        chk({tag, "_sys"}, 64'(bus.ii_systolic), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_jrdy"}, 64'(bus.job_ready), 64'd0);
        chk({tag, "_srdy"}, 64'(bus.src_ready), 64'd0);
        chk({tag, "_pulses"}, {61'd0, bus.job_done, bus.job_err, bus.job_aborted}, 64'd0);
    endtask

    // Cycle 0 is the cycle job_valid is presented; exp_done < 0 means only bounded.
    task automatic run_job(input string tag, input logic [4:0] beats, input bit sys,
                           input bit gaps, input int exp_done, input logic [63:0] cfg);
        int  idx = 0;
        int  g = 0;
        int  nfwd = 0;
        int  done_cyc = -1;
        int  dones = 0;
        bit  acc;
        logic [63:0] exp_pair;
        bus.job_cfg      = cfg;
        bus.job_beats    = beats;
        bus.job_systolic = sys;
        bus.job_valid    = 1'b1;
        bus.src_valid    = 1'b1;
        bus.src_data     = pair(0);
        for (int cyc = 1; cyc < 100 && done_cyc < 0; cyc++) begin
            acc = bus.src_valid & bus.src_ready;
            tick();
            bus.job_valid = 1'b0;
            if (acc) idx++;
            g++;
            bus.src_valid = gaps ? (g % 3 == 0) : 1'b1;
            bus.src_data  = pair(idx);
            if (cyc == 1) begin
                chk({tag, "_cfg"}, bus.ii_cfg, cfg);
                chk({tag, "_cfg_load"}, 64'(bus.ii_load), 64'd0);
                chk({tag, "_cfg_dir"}, 64'(bus.ii_dir), 64'd1);
                chk({tag, "_cfg_data"}, 64'(bus.ii_data_1), 64'd0);
                chk({tag, "_sys"}, 64'(bus.ii_systolic), 64'(sys));
                chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
            end else begin
                chk({tag, "_load"}, 64'(bus.ii_load), 64'(!acc));
                if (acc) begin
                    exp_pair = pair(nfwd);
                    chk({tag, "_data"}, {bus.ii_data_2, bus.ii_data_1}, exp_pair);
                    chk({tag, "_dir"}, 64'(bus.ii_dir), 64'(nfwd < int'(beats)));
                    nfwd++;
                end
            end
            if (bus.job_done) begin
                done_cyc = cyc;
                dones++;
            end
        end
        chk({tag, "_nfwd"}, 64'(nfwd), 64'(2 * int'(beats)));
        if (exp_done >= 0) chk({tag, "_done_cyc"}, 64'(done_cyc), 64'(exp_done));
        else               chk({tag, "_done_seen"}, 64'(dones), 64'd1);
        tick();
        chk({tag, "_after_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_after_jrdy"}, 64'(bus.job_ready), 64'd1);
        chk({tag, "_after_done"}, 64'(bus.job_done), 64'd0);
        chk({tag, "_cfg_held"}, bus.ii_cfg, cfg);
    endtask

    task automatic bad_job(input string tag, input logic [4:0] beats);
        bus.job_cfg   = 64'hDEAD_BEEF_0000_0001;
        bus.job_beats = beats;
        bus.job_valid = 1'b1;
        tick();
        bus.job_valid = 1'b0;
        chk({tag, "_err"}, 64'(bus.job_err), 64'd1);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_load"}, 64'(bus.ii_load), 64'd1);
        chk({tag, "_jrdy"}, 64'(bus.job_ready), 64'd1);
        tick();
        chk({tag, "_err_clr"}, 64'(bus.job_err), 64'd0);
        chk({tag, "_load2"}, 64'(bus.ii_load), 64'd1);
        chk({tag, "_busy2"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int dones;
        reset            = 1'b0;
        bus.job_valid    = 1'b0;
        bus.job_cfg      = '0;
        bus.job_beats    = '0;
        bus.job_systolic = 1'b0;
        bus.abort        = 1'b0;
        bus.src_valid    = 1'b0;
        bus.src_data     = '0;
        tick();
        tick();
        check_reset_values("rst_init");
        reset = 1'b1;
        tick();
        chk("rst_jrdy", 64'(bus.job_ready), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);

        // Reset in the middle of FEED_W, second of four beats on the outputs
        bus.job_cfg      = 64'h1111_2222_3333_4444;
        bus.job_beats    = 5'd4;
        bus.job_systolic = 1'b1;
        bus.job_valid    = 1'b1;
        bus.src_valid    = 1'b1;
        bus.src_data     = pair(7);
        tick();
        bus.job_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_dir_before", 64'(bus.ii_dir), 64'd1);
        chk("mid_busy_before", 64'(bus.busy), 64'd1);
        #3 reset = 1'b0;
        #1;
        check_reset_values("rst_mid");
        bus.src_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("rst_mid_jrdy", 64'(bus.job_ready), 64'd1);
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);

        run_job("plain", 5'd2, 1'b0, 1'b0, 7, 64'h0123_4567_89AB_CDEF);
        run_job("systolic", 5'd2, 1'b1, 1'b0, 13, 64'hFEDC_BA98_7654_3210);
        run_job("gaps", 5'd3, 1'b0, 1'b1, -1, 64'h5555_AAAA_0F0F_F0F0);

        bad_job("beats0", 5'd0);
        bad_job("beats17", 5'd17);

        // Abort while the first north pair is being offered
        bus.job_cfg      = 64'h0000_0000_CAFE_F00D;
        bus.job_beats    = 5'd2;
        bus.job_systolic = 1'b0;
        bus.job_valid    = 1'b1;
        bus.src_valid    = 1'b1;
        bus.src_data     = pair(0);
        tick();
        bus.job_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_pre_dir", 64'(bus.ii_dir), 64'd1);
        chk("abort_pre_srdy", 64'(bus.src_ready), 64'd1);
        bus.src_data = pair(2);
        bus.abort    = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_pulse", 64'(bus.job_aborted), 64'd1);
        chk("abort_load", 64'(bus.ii_load), 64'd1);
        chk("abort_srdy", 64'(bus.src_ready), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_jrdy", 64'(bus.job_ready), 64'd1);
        chk("abort_done", 64'(bus.job_done), 64'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.job_done || bus.job_aborted || bus.busy) dones++;
        end
        chk("abort_quiet", 64'(dones), 64'd0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_idle_ignored", 64'(bus.job_aborted), 64'd0);

        run_job("post_abort", 5'd2, 1'b0, 1'b0, 7, 64'h0BAD_F00D_1234_5678);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
